// File: rtl/mem_word_access_unit.sv
// Multi-byte little-endian load/store sequencer in front of the byte-wide Memory block.
// Optional misalignment check enabled by defining MEM_WORD_ACCESS_ALIGN_CHECK_EN.
module mem_word_access_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [7:0]        Mem_Data,
    output logic              Mem_WR,
    output logic              Mem_CS,
    input  logic [7:0]        Mem_Out
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;
    logic              err_q;
    logic              misaligned;

`ifdef MEM_WORD_ACCESS_ALIGN_CHECK_EN
    assign misaligned = (Addr % ADDR_W'(NBYTES)) != '0;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        base_q  <= Addr;
                        wdata_q <= WData;
                        write_q <= Write;
                        err_q   <= misaligned;
                        cnt     <= '0;
                    end
                end
                S_XFER: begin
                    if (!write_q) begin
                        rdata_q[8*int'(cnt) +: 8] <= Mem_Out;
                    end
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobes decode straight from state so Reset drops Mem_CS without waiting for an edge.
    always_comb begin
        state_nxt   = state;
        Busy        = 1'b0;
        Done        = 1'b0;
        Err         = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        Mem_Address = '0;
        Mem_Data    = '0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = misaligned ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                Busy        = 1'b1;
                Mem_CS      = 1'b0;
                Mem_WR      = write_q;
                Mem_Address = base_q + ADDR_W'(cnt);
                Mem_Data    = write_q ? wdata_q[8*int'(cnt) +: 8] : 8'h00;
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                Err       = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign RData = rdata_q;

endmodule

// File: tb/tb_mem_word_access_unit.sv
// Directed bench: 16-bit and 32-bit instances, each with its own byte memory model.
module tb_mem_word_access_unit;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    logic        s16_start, s16_write;
    logic [15:0] s16_addr, s16_wdata;
    logic        d16_busy, d16_done, d16_err;
    logic [15:0] d16_rdata, m16_addr;
    logic [7:0]  m16_data, m16_out;
    logic        m16_wr, m16_cs;

    logic        s32_start, s32_write;
    logic [15:0] s32_addr;
    logic [31:0] s32_wdata;
    logic        d32_busy, d32_done, d32_err;
    logic [31:0] d32_rdata;
    logic [15:0] m32_addr;
    logic [7:0]  m32_data, m32_out;
    logic        m32_wr, m32_cs;

    logic [7:0] mem16 [0:65535];
    logic [7:0] mem32 [0:65535];

    int tests_run = 0;
    int tests_failed = 0;
    int cs16_cycles = 0;
    int done16_count = 0;

    mem_word_access_unit #(.DATA_W(16), .ADDR_W(16)) dut16 (
        .Clock(Clock), .Reset(Reset), .Start(s16_start), .Write(s16_write),
        .Addr(s16_addr), .WData(s16_wdata), .Busy(d16_busy), .Done(d16_done),
        .Err(d16_err), .RData(d16_rdata), .Mem_Address(m16_addr), .Mem_Data(m16_data),
        .Mem_WR(m16_wr), .Mem_CS(m16_cs), .Mem_Out(m16_out)
    );

    mem_word_access_unit #(.DATA_W(32), .ADDR_W(16)) dut32 (
        .Clock(Clock), .Reset(Reset), .Start(s32_start), .Write(s32_write),
        .Addr(s32_addr), .WData(s32_wdata), .Busy(d32_busy), .Done(d32_done),
        .Err(d32_err), .RData(d32_rdata), .Mem_Address(m32_addr), .Mem_Data(m32_data),
        .Mem_WR(m32_wr), .Mem_CS(m32_cs), .Mem_Out(m32_out)
    );

    assign m16_out = mem16[m16_addr];
    assign m32_out = mem32[m32_addr];

    always @(posedge Clock) begin
        if (!m16_cs && m16_wr) mem16[m16_addr] <= m16_data;
        if (!m32_cs && m32_wr) mem32[m32_addr] <= m32_data;
        if (!m16_cs) cs16_cycles <= cs16_cycles + 1;
        if (d16_done) done16_count <= done16_count + 1;
    end

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    // Raise Start for one edge; returns #1 after the accepting edge with inputs scrambled.
    task automatic go16(input logic wr, input logic [15:0] a, input logic [15:0] d);
        s16_start = 1'b1; s16_write = wr; s16_addr = a; s16_wdata = d;
        step();
        s16_start = 1'b0; s16_write = ~wr; s16_addr = 16'hFFFF; s16_wdata = 16'h0000;
    endtask

    task automatic go32(input logic wr, input logic [15:0] a, input logic [31:0] d);
        s32_start = 1'b1; s32_write = wr; s32_addr = a; s32_wdata = d;
        step();
        s32_start = 1'b0; s32_write = ~wr; s32_addr = 16'h0000; s32_wdata = '0;
    endtask

    task automatic test_reset;
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got=%0h exp=0", d16_busy); end
        tests_run++; if (d16_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got=%0h exp=0", d16_done); end
        tests_run++; if (d16_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err got=%0h exp=0", d16_err); end
        tests_run++; if (d16_rdata !== 16'h0000) begin tests_failed++; $display("FAIL rst_rdata got=%0h exp=0", d16_rdata); end
        tests_run++; if (m16_cs !== 1'b1) begin tests_failed++; $display("FAIL rst_cs got=%0h exp=1", m16_cs); end
        tests_run++; if (m16_wr !== 1'b0) begin tests_failed++; $display("FAIL rst_wr got=%0h exp=0", m16_wr); end
        tests_run++; if (m16_addr !== 16'h0000) begin tests_failed++; $display("FAIL rst_addr got=%0h exp=0", m16_addr); end
        tests_run++; if (m16_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data got=%0h exp=0", m16_data); end
        tests_run++; if (d32_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata32 got=%0h exp=0", d32_rdata); end
        tests_run++; if (m32_cs !== 1'b1) begin tests_failed++; $display("FAIL rst_cs32 got=%0h exp=1", m32_cs); end
    endtask

    task automatic test_store16;
        go16(1'b1, 16'h0010, 16'hABCD);
        tests_run++; if (m16_cs !== 1'b0) begin tests_failed++; $display("FAIL st_c1_cs got=%0h exp=0", m16_cs); end
        tests_run++; if (m16_wr !== 1'b1) begin tests_failed++; $display("FAIL st_c1_wr got=%0h exp=1", m16_wr); end
        tests_run++; if (m16_addr !== 16'h0010) begin tests_failed++; $display("FAIL st_c1_addr got=%0h exp=10", m16_addr); end
        tests_run++; if (m16_data !== 8'hCD) begin tests_failed++; $display("FAIL st_c1_data got=%0h exp=cd", m16_data); end
        tests_run++; if (d16_busy !== 1'b1) begin tests_failed++; $display("FAIL st_c1_busy got=%0h exp=1", d16_busy); end
        step();
        tests_run++; if (m16_addr !== 16'h0011) begin tests_failed++; $display("FAIL st_c2_addr got=%0h exp=11", m16_addr); end
        tests_run++; if (m16_data !== 8'hAB) begin tests_failed++; $display("FAIL st_c2_data got=%0h exp=ab", m16_data); end
        tests_run++; if (d16_done !== 1'b0) begin tests_failed++; $display("FAIL st_c2_done got=%0h exp=0", d16_done); end
        step();
        tests_run++; if (d16_done !== 1'b1) begin tests_failed++; $display("FAIL st_c3_done got=%0h exp=1", d16_done); end
        tests_run++; if (d16_busy !== 1'b1) begin tests_failed++; $display("FAIL st_c3_busy got=%0h exp=1", d16_busy); end
        tests_run++; if (m16_cs !== 1'b1) begin tests_failed++; $display("FAIL st_c3_cs got=%0h exp=1", m16_cs); end
        tests_run++; if (d16_err !== 1'b0) begin tests_failed++; $display("FAIL st_c3_err got=%0h exp=0", d16_err); end
        tests_run++; if (d16_rdata !== 16'h0000) begin tests_failed++; $display("FAIL st_rdata_kept got=%0h exp=0", d16_rdata); end
        step();
        tests_run++; if (d16_done !== 1'b0) begin tests_failed++; $display("FAIL st_c4_done got=%0h exp=0", d16_done); end
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL st_c4_busy got=%0h exp=0", d16_busy); end
        tests_run++; if (mem16[16'h0010] !== 8'hCD) begin tests_failed++; $display("FAIL st_mem10 got=%0h exp=cd", mem16[16'h0010]); end
        tests_run++; if (mem16[16'h0011] !== 8'hAB) begin tests_failed++; $display("FAIL st_mem11 got=%0h exp=ab", mem16[16'h0011]); end
    endtask

    task automatic test_load16;
        go16(1'b0, 16'h0010, 16'h5555);
        tests_run++; if (m16_cs !== 1'b0) begin tests_failed++; $display("FAIL ld_c1_cs got=%0h exp=0", m16_cs); end
        tests_run++; if (m16_wr !== 1'b0) begin tests_failed++; $display("FAIL ld_c1_wr got=%0h exp=0", m16_wr); end
        tests_run++; if (m16_addr !== 16'h0010) begin tests_failed++; $display("FAIL ld_c1_addr got=%0h exp=10", m16_addr); end
        step();
        tests_run++; if (m16_wr !== 1'b0) begin tests_failed++; $display("FAIL ld_c2_wr got=%0h exp=0", m16_wr); end
        tests_run++; if (m16_addr !== 16'h0011) begin tests_failed++; $display("FAIL ld_c2_addr got=%0h exp=11", m16_addr); end
        step();
        tests_run++; if (d16_done !== 1'b1) begin tests_failed++; $display("FAIL ld_c3_done got=%0h exp=1", d16_done); end
        tests_run++; if (d16_rdata !== 16'hABCD) begin tests_failed++; $display("FAIL ld_c3_rdata got=%0h exp=abcd", d16_rdata); end
        step();
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL ld_c4_busy got=%0h exp=0", d16_busy); end
        tests_run++; if (d16_rdata !== 16'hABCD) begin tests_failed++; $display("FAIL ld_hold_rdata got=%0h exp=abcd", d16_rdata); end
        tests_run++; if (mem16[16'h0010] !== 8'hCD) begin tests_failed++; $display("FAIL ld_mem_intact got=%0h exp=cd", mem16[16'h0010]); end
    endtask

    task automatic test_start_while_busy;
        int c0, d0;
        mem16[16'h0030] = 8'h12; mem16[16'h0031] = 8'h34;
        mem16[16'h0040] = 8'h99; mem16[16'h0041] = 8'h88;
        c0 = cs16_cycles; d0 = done16_count;
        go16(1'b0, 16'h0030, 16'h0000);
        s16_start = 1'b1; s16_write = 1'b1; s16_addr = 16'h0040;
        step();
        s16_start = 1'b0;
        step();
        tests_run++; if (d16_done !== 1'b1) begin tests_failed++; $display("FAIL bb_done got=%0h exp=1", d16_done); end
        s16_start = 1'b1; s16_write = 1'b0; s16_addr = 16'h0040;
        step();
        s16_start = 1'b0;
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL bb_idle1 got=%0h exp=0", d16_busy); end
        step();
        step();
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL bb_idle3 got=%0h exp=0", d16_busy); end
        tests_run++; if (d16_rdata !== 16'h3412) begin tests_failed++; $display("FAIL bb_rdata got=%0h exp=3412", d16_rdata); end
        tests_run++; if (cs16_cycles - c0 !== 2) begin tests_failed++; $display("FAIL bb_memcycles got=%0d exp=2", cs16_cycles - c0); end
        tests_run++; if (done16_count - d0 !== 1) begin tests_failed++; $display("FAIL bb_donecount got=%0d exp=1", done16_count - d0); end
        tests_run++; if (mem16[16'h0040] !== 8'h99) begin tests_failed++; $display("FAIL bb_mem40 got=%0h exp=99", mem16[16'h0040]); end
    endtask

`ifdef MEM_WORD_ACCESS_ALIGN_CHECK_EN
    task automatic test_align16;
        int c0;
        c0 = cs16_cycles;
        go16(1'b0, 16'h0011, 16'h0000);
        tests_run++; if (m16_cs !== 1'b1) begin tests_failed++; $display("FAIL al_cs got=%0h exp=1", m16_cs); end
        tests_run++; if (d16_done !== 1'b1) begin tests_failed++; $display("FAIL al_done got=%0h exp=1", d16_done); end
        tests_run++; if (d16_err !== 1'b1) begin tests_failed++; $display("FAIL al_err got=%0h exp=1", d16_err); end
        tests_run++; if (d16_rdata !== 16'h3412) begin tests_failed++; $display("FAIL al_rdata got=%0h exp=3412", d16_rdata); end
        step();
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL al_idle got=%0h exp=0", d16_busy); end
        tests_run++; if (d16_err !== 1'b0) begin tests_failed++; $display("FAIL al_err_clr got=%0h exp=0", d16_err); end
        tests_run++; if (cs16_cycles !== c0) begin tests_failed++; $display("FAIL al_memcycles got=%0d exp=%0d", cs16_cycles, c0); end
    endtask
`endif

    task automatic test_wrap32;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        mem32[16'hFFFE] = 8'h11; mem32[16'hFFFF] = 8'h22;
        mem32[16'h0000] = 8'h33; mem32[16'h0001] = 8'h44;
        go32(1'b0, 16'hFFFE, 32'h0);
`ifdef MEM_WORD_ACCESS_ALIGN_CHECK_EN
        tests_run++; if (m32_cs !== 1'b1) begin tests_failed++; $display("FAIL w32_cs got=%0h exp=1", m32_cs); end
        tests_run++; if (d32_done !== 1'b1) begin tests_failed++; $display("FAIL w32_done got=%0h exp=1", d32_done); end
        tests_run++; if (d32_err !== 1'b1) begin tests_failed++; $display("FAIL w32_err got=%0h exp=1", d32_err); end
        tests_run++; if (d32_rdata !== 32'h0) begin tests_failed++; $display("FAIL w32_rdata got=%0h exp=0", d32_rdata); end
`else
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (m32_cs !== 1'b0 || m32_wr !== 1'b0 || m32_addr !== exp_a[i]) begin
                tests_failed++; $display("FAIL w32_c%0d cs=%0h wr=%0h addr=%0h exp cs=0 wr=0 addr=%0h", i + 1, m32_cs, m32_wr, m32_addr, exp_a[i]);
            end
            tests_run++; if (d32_done !== 1'b0) begin tests_failed++; $display("FAIL w32_early_done c%0d got=%0h exp=0", i + 1, d32_done); end
            step();
        end
        tests_run++; if (d32_done !== 1'b1) begin tests_failed++; $display("FAIL w32_done got=%0h exp=1", d32_done); end
        tests_run++; if (d32_err !== 1'b0) begin tests_failed++; $display("FAIL w32_err got=%0h exp=0", d32_err); end
        tests_run++; if (d32_rdata !== 32'h44332211) begin tests_failed++; $display("FAIL w32_rdata got=%0h exp=44332211", d32_rdata); end
`endif
        step();
        tests_run++; if (d32_busy !== 1'b0) begin tests_failed++; $display("FAIL w32_idle got=%0h exp=0", d32_busy); end
    endtask

    task automatic test_reset_mid;
        int d0;
        mem16[16'h0020] = 8'h00; mem16[16'h0021] = 8'h5A;
        d0 = done16_count;
        go16(1'b1, 16'h0020, 16'h1234);
        step();
        Reset = 1'b1;
        #1;
        tests_run++; if (m16_cs !== 1'b1) begin tests_failed++; $display("FAIL rm_cs got=%0h exp=1", m16_cs); end
        tests_run++; if (d16_busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy got=%0h exp=0", d16_busy); end
        step();
        Reset = 1'b0;
        step();
        tests_run++; if (mem16[16'h0020] !== 8'h34) begin tests_failed++; $display("FAIL rm_mem20 got=%0h exp=34", mem16[16'h0020]); end
        tests_run++; if (mem16[16'h0021] !== 8'h5A) begin tests_failed++; $display("FAIL rm_mem21 got=%0h exp=5a", mem16[16'h0021]); end
        tests_run++; if (done16_count !== d0) begin tests_failed++; $display("FAIL rm_nodone got=%0d exp=%0d", done16_count, d0); end
        go16(1'b1, 16'h0020, 16'h1234);
        step();
        step();
        tests_run++; if (d16_done !== 1'b1) begin tests_failed++; $display("FAIL rm_retry_done got=%0h exp=1", d16_done); end
        step();
        tests_run++; if (mem16[16'h0021] !== 8'h12) begin tests_failed++; $display("FAIL rm_retry_mem21 got=%0h exp=12", mem16[16'h0021]); end
        tests_run++; if (mem16[16'h0020] !== 8'h34) begin tests_failed++; $display("FAIL rm_retry_mem20 got=%0h exp=34", mem16[16'h0020]); end
    endtask

    initial begin
        Reset = 1'b1;
        s16_start = 1'b0; s16_write = 1'b0; s16_addr = '0; s16_wdata = '0;
        s32_start = 1'b0; s32_write = 1'b0; s32_addr = '0; s32_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem16[i] = 8'h00;
            mem32[i] = 8'h00;
        end
        #1;
        test_reset();
        step();
        step();
        Reset = 1'b0;
        step();
        test_store16();
        test_load16();
        test_start_while_busy();
`ifdef MEM_WORD_ACCESS_ALIGN_CHECK_EN
        test_align16();
`endif
        test_wrap32();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
